bit_sync_filt: RTL and testbench

Parametrised multi-channel synchroniser with glitch filter and edge detection for asynchronous level inputs (buttons, straps, interrupt lines, status bits from other domains) entering the `dest_clk` domain. Each of `WIDTH` independent channels passes through a `NUM_OF_FLOPS`-deep synchroniser chain. A per-channel qualification counter follows the chain and accepts a new level only after it has been stable for `FILTER_CYCLES` consecutive cycles. Registered one-cycle `rise`/`fall` pulses accompany every accepted transition. The block sits at the boundary of any domain that consumes slow asynchronous single-bit signals.

---
 rtl/bit_sync_pkg.sv | 16 +
 rtl/bit_sync_filt_ch.sv | 73 +++++++
 rtl/bit_sync_filt.sv | 50 +++++
 tb/tb_bit_sync_filt.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bit_sync_pkg.sv
// Shared types and helpers for the bit_sync_filt multi-channel synchroniser/filter.
package bit_sync_pkg;

    // A counter that only has to reach FILTER_CYCLES-1 still needs at least one bit.
    function automatic int cnt_width(input int filter_cycles);
        int w;
        w = $clog2(filter_cycles);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic rise;
        logic fall;
    } sync_edge_t;

endpackage

// File: rtl/bit_sync_filt_ch.sv
// One channel: synchroniser chain, stability qualification counter, filtered level
// and registered one-cycle edge pulses.
module bit_sync_filt_ch
    import bit_sync_pkg::*;
#(
    parameter int   NUM_OF_FLOPS  = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic       dest_clk,
    input  logic       rst,
    input  logic       d_i,
    output logic       sync_raw_o,
    output logic       d_o,
    output sync_edge_t edge_o
);

    localparam int                CNT_W   = cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    logic [NUM_OF_FLOPS-1:0] chain_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    level_q, level_d;
    sync_edge_t              edge_q, edge_d;
    logic                    sync_raw;

    assign sync_raw = chain_q[NUM_OF_FLOPS-1];

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values;
    // blocking here would collapse the chain into a single stage.
    always_ff @(posedge dest_clk) begin
        if (rst) begin
            chain_q <= {NUM_OF_FLOPS{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[NUM_OF_FLOPS-2:0], d_i};
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        edge_d  = '0;
        if (sync_raw == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d     = sync_raw;
            cnt_d       = '0;
            edge_d.rise = sync_raw;
            edge_d.fall = ~sync_raw;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge dest_clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= RESET_VAL;
            edge_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            edge_q  <= edge_d;
        end
    end

    assign sync_raw_o = sync_raw;
    assign d_o        = level_q;
    assign edge_o     = edge_q;

endmodule

// File: rtl/bit_sync_filt.sv
// WIDTH independent synchroniser + glitch-filter channels for slow asynchronous
// level inputs entering the dest_clk domain.
module bit_sync_filt
    import bit_sync_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               NUM_OF_FLOPS  = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             dest_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D_in,
    output logic [WIDTH-1:0] sync_raw,
    output logic [WIDTH-1:0] D_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (WIDTH < 1) begin : g_bad_width
        $error("bit_sync_filt: WIDTH must be >= 1");
    end
    if (NUM_OF_FLOPS < 2) begin : g_bad_flops
        $error("bit_sync_filt: NUM_OF_FLOPS must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("bit_sync_filt: FILTER_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_edge_t edge_w;

        bit_sync_filt_ch #(
            .NUM_OF_FLOPS  (NUM_OF_FLOPS),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_ch (
            .dest_clk   (dest_clk),
            .rst        (rst),
            .d_i        (D_in[i]),
            .sync_raw_o (sync_raw[i]),
            .d_o        (D_out[i]),
            .edge_o     (edge_w)
        );

        assign rise[i] = edge_w.rise;
        assign fall[i] = edge_w.fall;
    end

endmodule

// File: tb/tb_bit_sync_filt.sv
// Directed scenarios plus randomized traffic on two configurations of bit_sync_filt,
// compared every cycle against a timestamp-based reference model.
module tb_bit_sync_filt;

    localparam int W    = 4;
    localparam int MAXE = 4096;

    logic         dest_clk = 1'b0;
    logic         rst_a, rst_b;
    logic [W-1:0] din_a, din_b;
    logic [W-1:0] sr_a, do_a, ri_a, fa_a;
    logic [W-1:0] sr_b, do_b, ri_b, fa_b;

    int checks = 0;
    int errors = 0;

    always #5 dest_clk = ~dest_clk;

    bit_sync_filt #(
        .WIDTH(W), .NUM_OF_FLOPS(2), .FILTER_CYCLES(3), .RESET_VAL(4'b1000)
    ) dut_a (
        .dest_clk(dest_clk), .rst(rst_a), .D_in(din_a),
        .sync_raw(sr_a), .D_out(do_a), .rise(ri_a), .fall(fa_a)
    );

    bit_sync_filt #(
        .WIDTH(W), .NUM_OF_FLOPS(3), .FILTER_CYCLES(1), .RESET_VAL(4'b0000)
    ) dut_b (
        .dest_clk(dest_clk), .rst(rst_b), .D_in(din_b),
        .sync_raw(sr_b), .D_out(do_b), .rise(ri_b), .fall(fa_b)
    );

    // Reference model: sync_raw is the input sampled NUM edges earlier (or the reset
    // level if a reset edge lies in that window); a level is accepted once sync_raw
    // has differed from D_out for FILTER edges since the later of its last change
    // and the last accept/reset.
    int           m_num  [2] = '{2, 3};
    int           m_filt [2] = '{3, 1};
    logic [W-1:0] m_rv   [2] = '{4'b1000, 4'b0000};
    logic [W-1:0] din_h  [2][MAXE];
    bit           rst_h  [2][MAXE];
    logic [W-1:0] m_sr   [2] = '{4'b1000, 4'b0000};
    logic [W-1:0] m_dout [2] = '{4'b1000, 4'b0000};
    logic [W-1:0] m_rise [2] = '{4'b0000, 4'b0000};
    logic [W-1:0] m_fall [2] = '{4'b0000, 4'b0000};
    int           last_chg [2][W];
    int           last_evt [2][W];
    int           t = 0;

    function automatic logic [W-1:0] sync_at(input int k, input int e);
        for (int j = e - m_num[k] + 1; j <= e; j++) begin
            if (j < 1 || rst_h[k][j]) return m_rv[k];
        end
        return din_h[k][e - m_num[k] + 1];
    endfunction

    task automatic model_edge();
        logic [W-1:0] nsr;
        int since;
        t++;
        if (t >= MAXE) begin
            $display("FAIL model_capacity edge %0d limit %0d", t, MAXE);
            $fatal(1, "history overflow");
        end
        din_h[0][t] = din_a; rst_h[0][t] = rst_a;
        din_h[1][t] = din_b; rst_h[1][t] = rst_b;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < W; i++) begin
                since = t - ((last_chg[k][i] > last_evt[k][i]) ? last_chg[k][i] : last_evt[k][i]);
                m_rise[k][i] = 1'b0;
                m_fall[k][i] = 1'b0;
                if (rst_h[k][t]) begin
                    m_dout[k][i]   = m_rv[k][i];
                    last_evt[k][i] = t;
                end else if (m_sr[k][i] != m_dout[k][i] && since >= m_filt[k]) begin
                    m_rise[k][i]   = m_sr[k][i];
                    m_fall[k][i]   = ~m_sr[k][i];
                    m_dout[k][i]   = m_sr[k][i];
                    last_evt[k][i] = t;
                end
            end
            nsr = sync_at(k, t);
            for (int i = 0; i < W; i++) begin
                if (nsr[i] != m_sr[k][i]) last_chg[k][i] = t;
            end
            m_sr[k] = nsr;
        end
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge %0d observed %b expected %b", tag, t, obs, exp);
        end
    endtask

    // One clock edge: model advances at the edge, outputs are compared mid-cycle.
    task automatic step();
        @(posedge dest_clk);
        model_edge();
        @(negedge dest_clk);
        check("A.sync_raw", sr_a, m_sr[0]);
        check("A.D_out",    do_a, m_dout[0]);
        check("A.rise",     ri_a, m_rise[0]);
        check("A.fall",     fa_a, m_fall[0]);
        check("B.sync_raw", sr_b, m_sr[1]);
        check("B.D_out",    do_b, m_dout[1]);
        check("B.rise",     ri_b, m_rise[1]);
        check("B.fall",     fa_b, m_fall[1]);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < W; i++) begin
                last_chg[k][i] = 0;
                last_evt[k][i] = 0;
            end
        rst_a = 1'b1; rst_b = 1'b1;
        din_a = 4'hF; din_b = 4'h0;

        // Reset held for three edges with all inputs high.
        repeat (3) begin
            step();
            check("s1.rst_dout", do_a, 4'b1000);
            check("s1.rst_sync", sr_a, 4'b1000);
            check("s1.rst_rise", ri_a, 4'b0000);
            check("s1.rst_fall", fa_a, 4'b0000);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            check("s1.rise", ri_a, (e == 5) ? 4'b0111 : 4'b0000);
        end

        // Clean rising edge on channel 0.
        din_a = 4'b1000;
        repeat (8) step();
        din_a = 4'b1001;
        for (int e = 1; e <= 6; e++) begin
            step();
            check("s2.sync", sr_a, (e >= 2) ? 4'b1001 : 4'b1000);
            check("s2.dout", do_a, (e >= 5) ? 4'b1001 : 4'b1000);
            check("s2.rise", ri_a, (e == 5) ? 4'b0001 : 4'b0000);
            check("s2.fall", fa_a, 4'b0000);
        end

        // Two-cycle glitch on channel 1 is discarded.
        din_a = 4'b1011;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 2) din_a = 4'b1001;
            check("s3.glitch_sync", sr_a, (e == 2 || e == 3) ? 4'b1011 : 4'b1001);
            check("s3.glitch_dout", do_a, 4'b1001);
            check("s3.glitch_rise", ri_a, 4'b0000);
            check("s3.glitch_fall", fa_a, 4'b0000);
        end

        // Three-cycle pulse on channel 1 is accepted, then released.
        din_a = 4'b1011;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (e == 3) din_a = 4'b1001;
            check("s3.pulse_dout", do_a, (e >= 5 && e < 8) ? 4'b1011 : 4'b1001);
            check("s3.pulse_rise", ri_a, (e == 5) ? 4'b0010 : 4'b0000);
            check("s3.pulse_fall", fa_a, (e == 8) ? 4'b0010 : 4'b0000);
        end

        // Simultaneous rise and fall on different channels.
        din_a = 4'b1000;
        repeat (8) step();
        din_a = 4'b0100;
        for (int e = 1; e <= 6; e++) begin
            step();
            check("s4.rise", ri_a, (e == 5) ? 4'b0100 : 4'b0000);
            check("s4.fall", fa_a, (e == 5) ? 4'b1000 : 4'b0000);
            check("s4.dout", do_a, (e >= 5) ? 4'b0100 : 4'b1000);
        end

        // Reset in the middle of qualifying channel 2.
        din_a = 4'b0000;
        repeat (8) step();
        din_a = 4'b0100;
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) rst_a = 1'b1;
            if (e == 6) rst_a = 1'b0;
            step();
            check("s5.dout", do_a, (e < 4) ? 4'b0000 : (e < 10) ? 4'b1000 : 4'b0100);
            check("s5.rise", ri_a, (e == 10) ? 4'b0100 : 4'b0000);
            check("s5.fall", fa_a, (e == 10) ? 4'b1000 : 4'b0000);
        end

        // Minimum filter, three-flop chain.
        din_b = 4'b0001;
        for (int e = 1; e <= 5; e++) begin
            step();
            check("s6.dout", do_b, (e >= 4) ? 4'b0001 : 4'b0000);
            check("s6.rise", ri_b, (e == 4) ? 4'b0001 : 4'b0000);
        end
        din_b = 4'b0000;
        for (int e = 1; e <= 7; e++) begin
            if (e == 2) din_b = 4'b0001;
            step();
            check("s6.glitch_fall", fa_b, (e == 4) ? 4'b0001 : 4'b0000);
            check("s6.glitch_rise", ri_b, (e == 5) ? 4'b0001 : 4'b0000);
        end

        // Randomized traffic with occasional resets on both instances.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) din_a = W'($urandom);
            if ($urandom_range(0, 2) == 0) din_b = W'($urandom);
            rst_a = ($urandom_range(0, 59) == 0);
            rst_b = ($urandom_range(0, 59) == 0);
            step();
        end
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
